// File: rtl/pio_cfg_loader.sv
// Sequencer that loads a PIO program and its setup into one state machine
// through the PIO command port, then enables it, all from a single start pulse.
module pio_cfg_loader #(
    parameter int PROG_DEPTH = 32,
    parameter int INSTR_W    = 16
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic [5:0]         i_plen,
    input  logic [1:0]         i_msel,
    input  logic [31:0]        i_pend,
    input  logic [23:0]        i_div,
    input  logic [31:0]        i_pin_grps,
    input  logic               i_prog_we,
    input  logic [4:0]         i_prog_waddr,
    input  logic [INSTR_W-1:0] i_prog_wdata,
    output logic [5:0]         o_action,
    output logic [4:0]         o_index,
    output logic [1:0]         o_mindex,
    output logic [31:0]        o_din,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_err
);
    localparam logic [5:0] A_NONE  = 6'd0;
    localparam logic [5:0] A_INSTR = 6'd1;
    localparam logic [5:0] A_PEND  = 6'd2;
    localparam logic [5:0] A_GRPS  = 6'd5;
    localparam logic [5:0] A_EN    = 6'd6;
    localparam logic [5:0] A_DIV   = 6'd7;
    localparam logic [6:0] DEPTH_L = 7'(PROG_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_INSTR, S_PEND, S_DIV, S_GRPS, S_EN
    } state_t;

    // State names the command currently on the outputs, not the next one.
    state_t             r_state;
    logic [5:0]         r_cnt;
    logic [5:0]         r_plen;
    logic [31:0]        r_pend;
    logic [23:0]        r_div;
    logic [31:0]        r_grps;
    logic [5:0]         r_action;
    logic [4:0]         r_index;
    logic [1:0]         r_mindex;
    logic [31:0]        r_din;
    logic               r_busy;
    logic               r_done;
    logic               r_err;
    logic [INSTR_W-1:0] r_prog [PROG_DEPTH];

    logic               w_wr_en;
    logic [4:0]         w_rd_addr;
    logic [INSTR_W-1:0] w_rd_data;

    assign w_wr_en   = i_prog_we && !r_busy;
    assign w_rd_addr = (r_state == S_IDLE) ? 5'd0 : r_cnt[4:0];
    // Forward a same-cycle write so the first INSTR sees data written with start.
    assign w_rd_data = (w_wr_en && (i_prog_waddr == w_rd_addr)) ? i_prog_wdata
                                                                 : r_prog[w_rd_addr];

    always_ff @(posedge i_clk) begin
        if (w_wr_en)
            r_prog[i_prog_waddr] <= i_prog_wdata;
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_plen   <= '0;
            r_pend   <= '0;
            r_div    <= '0;
            r_grps   <= '0;
            r_action <= A_NONE;
            r_index  <= '0;
            r_mindex <= '0;
            r_din    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        if ({1'b0, i_plen} > DEPTH_L) begin
                            r_err <= 1'b1;
                        end else begin
                            r_plen   <= i_plen;
                            r_pend   <= i_pend;
                            r_div    <= i_div;
                            r_grps   <= i_pin_grps;
                            r_mindex <= i_msel;
                            r_busy   <= 1'b1;
                            r_index  <= '0;
                            if (i_plen == 6'd0) begin
                                r_state  <= S_PEND;
                                r_action <= A_PEND;
                                r_din    <= i_pend;
                            end else begin
                                r_state  <= S_INSTR;
                                r_action <= A_INSTR;
                                r_din    <= 32'(w_rd_data);
                                r_cnt    <= 6'd1;
                            end
                        end
                    end
                end
                S_INSTR: begin
                    if (r_cnt == r_plen) begin
                        r_state  <= S_PEND;
                        r_action <= A_PEND;
                        r_index  <= '0;
                        r_din    <= r_pend;
                    end else begin
                        r_action <= A_INSTR;
                        r_index  <= r_cnt[4:0];
                        r_din    <= 32'(w_rd_data);
                        r_cnt    <= r_cnt + 6'd1;
                    end
                end
                S_PEND: begin
                    r_state  <= S_DIV;
                    r_action <= A_DIV;
                    r_din    <= {8'b0, r_div};
                end
                S_DIV: begin
                    r_state  <= S_GRPS;
                    r_action <= A_GRPS;
                    r_din    <= r_grps;
                end
                S_GRPS: begin
                    r_state  <= S_EN;
                    r_action <= A_EN;
                    r_din    <= {28'b0, 4'(4'b0001 << r_mindex)};
                end
                S_EN: begin
                    r_state  <= S_IDLE;
                    r_action <= A_NONE;
                    r_index  <= '0;
                    r_mindex <= '0;
                    r_din    <= '0;
                    r_cnt    <= '0;
                    r_busy   <= 1'b0;
                    r_done   <= 1'b1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_action = r_action;
    assign o_index  = r_index;
    assign o_mindex = r_mindex;
    assign o_din    = r_din;
    assign o_busy   = r_busy;
    assign o_done   = r_done;
    assign o_err    = r_err;
endmodule

// File: doc/pio_cfg_loader.md
# pio_cfg_loader

Autonomous configuration sequencer that sits directly upstream of the `pio` block and drives its `action`/`index`/`mindex`/`din` command port. It holds a local program store and, on a single `start` pulse, replays the standard bring-up sequence into one state machine: instruction writes, PEND (exec control/wrap), DIV, GRPS, then EN. This replaces hand-driven command sequencing, so a PIO program can be loaded and launched by a single request from the host side.

## Interface

Parameters:
- `PROG_DEPTH`, default 32: program store entries. Must equal PIO instruction memory depth.
- `INSTR_W`, default 16: instruction width.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-low reset.
- `start`  in  1  launch request, sampled only in IDLE.
- `plen`  in  6  number of instructions to load (0..PROG_DEPTH).
- `msel`  in  2  target state machine.
- `pend`  in  32  PEND payload (exec control / wrap).
- `div`  in  24  clock divider payload.
- `pin_grps`  in  32  GRPS payload.
- `prog_we`  in  1  program store write enable.
- `prog_waddr`  in  5  program store write address.
- `prog_wdata`  in  INSTR_W  program store write data.
- `action`  out  6  PIO action code (NONE=0, INSTR=1, PEND=2, GRPS=5, EN=6, DIV=7).
- `index`  out  5  PIO instruction index.
- `mindex`  out  2  PIO machine index.
- `din`  out  32  PIO command data.
- `busy`  out  1  sequence in progress.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  one-cycle pulse on a rejected start.

## Operation

- Program store: `PROG_DEPTH` x `INSTR_W` register array. Synchronous write and asynchronous read. Writes occur only while `busy`=0; writes during `busy` are dropped.
- On `start` in IDLE, latch `plen`, `msel`, `pend`, `div`, and `pin_grps`. Input changes after that edge have no effect on the running sequence.
- If `plen` > PROG_DEPTH: pulse `err`, stay in IDLE, and issue no commands.
- FSM states and transitions: IDLE -> INSTR -> PEND -> DIV -> GRPS -> EN -> IDLE. With `plen`=0, IDLE goes directly to PEND.
- INSTR: one command per cycle for i = 0..plen-1. Drive `action`=1, `index`=i, `din`={16'b0, prog[i]}. A 6-bit counter tracks i, and the state exits after i = plen-1.
- PEND: `din`=pend.
- DIV: `din`={8'b0, div}.
- GRPS: `din`=pin_grps.
- EN: `din`={28'b0, 4'b0001 << msel}.
- `mindex` equals the latched `msel` in every non-IDLE state. `index` is 0 outside INSTR.
- In IDLE: `action`=0, `din`=0, `index`=0, `mindex`=0.
- `start` while `busy` is ignored and does not set `err`.

## Timing

- All outputs are registered and change only on the rising edge of `clk`.
- Reset values: `action`=0, `index`=0, `mindex`=0, `din`=0, `busy`=0, `done`=0, `err`=0. The program store is not reset.
- Sequence timing, with `start` sampled at edge 0:
  - Commands are valid in cycles 1..plen+4, each held exactly one cycle. The PIO samples each command on the following rising edge.
  - `busy`=1 in cycles 1..plen+4.
  - In cycle plen+5: `done`=1, `busy`=0, `action`=0.
  - A new `start` is accepted at the end of cycle plen+5.
- Rejected start: `err`=1 in cycle 1 only.
- Reset asserted mid-sequence: all outputs take reset values at the next edge. No `done`, no further commands. Latched config is discarded.
- Simultaneous `prog_we` and `start` in IDLE: the write completes. An INSTR read of the same address in cycle 1 returns the new data.

## Test plan

- Square-wave load:
  - Stimulus: prog[0]=16'hE081, prog[1]=16'hE001, plen=2, pend=32'h00001000, div=24'h000280, pin_grps=32'h04000000, msel=0.
  - Required command sequence, cycles 1..6, as (action, index, din): (1,0,0x0000E081), (1,1,0x0000E001), (2,0,0x00001000), (7,0,0x00000280), (5,0,0x04000000), (6,0,0x00000001).
  - `done` in cycle 7.
- `plen`=0, msel=3:
  - Cycles 1..4 carry PEND, DIV, GRPS, EN only.
  - EN `din`=0x00000008 and `mindex`=3.
  - `done` in cycle 5.
- `plen`=33: `err` pulses in cycle 1. `busy`, `action`, and `done` stay 0.
- Full load (`plen`=32, prog[i]=i):
  - INSTR indices run 0..31 with `din`=i.
  - `busy` is high for 36 cycles.
- During a run, a second `start` and a `prog_we` to address 0 with 16'hFFFF are both ignored. A subsequent run with `plen`=1 still loads the old prog[0].
- `reset` driven low in cycle 3 of the square-wave run: all outputs are 0 from the next edge and no `done` occurs. A fresh start afterwards replays the full sequence.
